// File: rtl/acc_exec_ctrl_pkg.sv
// Shared constants, FSM encoding and decode helpers for the accumulator/E
// execution controller.
package acc_exec_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_CLA = 4'd3;
  localparam logic [3:0] OP_CLE = 4'd4;
  localparam logic [3:0] OP_CMA = 4'd5;
  localparam logic [3:0] OP_CME = 4'd6;
  localparam logic [3:0] OP_CIR = 4'd7;
  localparam logic [3:0] OP_CIL = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_SPA = 4'd10;
  localparam logic [3:0] OP_SNA = 4'd11;
  localparam logic [3:0] OP_SZA = 4'd12;
  localparam logic [3:0] OP_SZE = 4'd13;

  localparam logic [2:0] ASEL_AND = 3'b000;
  localparam logic [2:0] ASEL_ADD = 3'b001;
  localparam logic [2:0] ASEL_LDA = 3'b010;
  localparam logic [2:0] ASEL_CMA = 3'b011;
  localparam logic [2:0] ASEL_CIR = 3'b100;
  localparam logic [2:0] ASEL_CIL = 3'b101;
  localparam logic [2:0] ASEL_NOP = 3'b110;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  function automatic logic op_is_mem(input logic [3:0] op);
    return op <= OP_LDA;
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_SZE;
  endfunction

  // INC reuses the adder with DR forced to 1.
  function automatic logic [2:0] op_asel(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_AND:  sel = ASEL_AND;
      OP_ADD:  sel = ASEL_ADD;
      OP_LDA:  sel = ASEL_LDA;
      OP_CMA:  sel = ASEL_CMA;
      OP_CIR:  sel = ASEL_CIR;
      OP_CIL:  sel = ASEL_CIL;
      OP_INC:  sel = ASEL_ADD;
      default: sel = ASEL_NOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_exec_ctrl_if.sv
// Instruction, memory-read and ALU signal bundle of the execution controller.
// The slave side is the controller; the master side is its environment.
interface acc_exec_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) ();

  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [ADDR_W-1:0] op_addr;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic [2:0]        aselect;
  logic [DATA_W-1:0] alu_ac;
  logic [DATA_W-1:0] alu_dr;
  logic              alu_e;
  logic [DATA_W:0]   alu_out;

  logic [DATA_W-1:0] ac;
  logic              e;
  logic              n_flag;
  logic              z_flag;
  logic              done;
  logic              skip;
  logic              err;

  modport slave (
    input  op_valid, op_code, op_addr, mem_ack, mem_rdata, alu_out,
    output op_ready, mem_req, mem_addr, aselect, alu_ac, alu_dr, alu_e,
    output ac, e, n_flag, z_flag, done, skip, err
  );

  modport master (
    output op_valid, op_code, op_addr, mem_ack, mem_rdata, alu_out,
    input  op_ready, mem_req, mem_addr, aselect, alu_ac, alu_dr, alu_e,
    input  ac, e, n_flag, z_flag, done, skip, err
  );

endinterface

// File: rtl/acc_fetch_timer.sv
// Counts cycles spent waiting for a memory read; flags the last allowed cycle.
module acc_fetch_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // expired is high during the final wait cycle so an ack there still wins.
  assign expired = run && (cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/acc_exec_ctrl.sv
// AC/E/DR register stage and micro-op sequencer around the external 16-bit ALU:
// accepts one op, fetches its operand if needed, executes, reports done/skip/err.
module acc_exec_ctrl
  import acc_exec_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst,
  acc_exec_ctrl_if.slave bus
);

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] ac_q;
  logic [DATA_W-1:0] dr_q;
  logic              e_q;
  logic              done_q;
  logic              skip_q;
  logic              err_q;
  logic              fetch_expired;

  acc_fetch_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == StFetch),
    .expired(fetch_expired)
  );

  assign bus.op_ready = (state_q == StIdle);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.aselect  = (state_q == StExec) ? op_asel(op_q) : ASEL_NOP;
  assign bus.alu_ac   = ac_q;
  assign bus.alu_dr   = dr_q;
  assign bus.alu_e    = e_q;
  assign bus.ac       = ac_q;
  assign bus.e        = e_q;
  assign bus.n_flag   = ac_q[DATA_W-1];
  assign bus.z_flag   = (ac_q == '0);
  assign bus.done     = done_q;
  assign bus.skip     = skip_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ac_q       <= '0;
      dr_q       <= '0;
      e_q        <= 1'b0;
      done_q     <= 1'b0;
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            op_q       <= bus.op_code;
            mem_addr_q <= bus.op_addr;
            if (op_is_mem(bus.op_code)) begin
              mem_req_q <= 1'b1;
              state_q   <= StFetch;
            end else begin
              // Illegal ops pass through a no-op EXEC so every register-class
              // op completes with the same two-cycle latency.
              if (bus.op_code == OP_INC) dr_q <= DATA_W'(1);
              state_q <= StExec;
            end
          end
        end
        StFetch: begin
          if (bus.mem_ack) begin
            dr_q      <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= StExec;
          end else if (fetch_expired) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= StDone;
          end
        end
        StExec: begin
          case (op_q)
            OP_AND, OP_LDA, OP_CMA, OP_INC: ac_q <= bus.alu_out[DATA_W-1:0];
            OP_ADD, OP_CIR, OP_CIL: begin
              ac_q <= bus.alu_out[DATA_W-1:0];
              e_q  <= bus.alu_out[DATA_W];
            end
            OP_CLA:  ac_q   <= '0;
            OP_CLE:  e_q    <= 1'b0;
            OP_CME:  e_q    <= ~e_q;
            OP_SPA:  skip_q <= ~ac_q[DATA_W-1];
            OP_SNA:  skip_q <= ac_q[DATA_W-1];
            OP_SZA:  skip_q <= (ac_q == '0);
            OP_SZE:  skip_q <= ~e_q;
            default: ;
          endcase
          err_q   <= op_is_illegal(op_q);
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          skip_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Directed bench for acc_exec_ctrl with a behavioural basic-computer ALU peer.
module tb_acc_exec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  acc_exec_ctrl_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  acc_exec_ctrl #(
    .DATA_W     (16),
    .ADDR_W     (12),
    .MEM_TIMEOUT(15)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: {E-out, AC-out}.
  always_comb begin
    bus.alu_out = 17'h0;
    case (bus.aselect)
      3'b000: bus.alu_out = {1'b0, bus.alu_ac & bus.alu_dr};
      3'b001: bus.alu_out = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
      3'b010: bus.alu_out = {1'b0, bus.alu_dr};
      3'b011: bus.alu_out = {1'b0, ~bus.alu_ac};
      3'b100: bus.alu_out = {bus.alu_ac[0], bus.alu_e, bus.alu_ac[15:1]};
      3'b101: bus.alu_out = {bus.alu_ac, bus.alu_e};
      default: bus.alu_out = 17'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a register op; done must land exactly two cycles after accept.
  task automatic reg_op(input logic [3:0] op, input logic [2:0] asel,
                        input logic skip_exp, input logic err_exp);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    tick();
    bus.op_valid = 1'b0;
    check("exec_aselect", 32'(bus.aselect), 32'(asel));
    check("exec_no_done", 32'(bus.done), 32'd0);
    tick();
    check("reg_done", 32'(bus.done), 32'd1);
    check("reg_skip", 32'(bus.skip), 32'(skip_exp));
    check("reg_err", 32'(bus.err), 32'(err_exp));
    tick();
    check("reg_ready", 32'(bus.op_ready), 32'd1);
    check("reg_done_pulse", 32'(bus.done), 32'd0);
  endtask

  // Issue a memory op and ack after `delay` waiting cycles.
  task automatic mem_op(input logic [3:0] op, input logic [11:0] addr,
                        input logic [15:0] data, input int delay);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_addr  = addr;
    tick();
    bus.op_valid = 1'b0;
    bus.op_addr  = 12'hFFF;
    for (int i = 0; i < delay; i++) begin
      check("fetch_req", 32'(bus.mem_req), 32'd1);
      check("fetch_addr", 32'(bus.mem_addr), 32'(addr));
      tick();
    end
    check("ack_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    check("exec_req_low", 32'(bus.mem_req), 32'd0);
    tick();
    check("mem_done", 32'(bus.done), 32'd1);
    check("mem_err", 32'(bus.err), 32'd0);
    tick();
    check("mem_done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_code   = 4'd0;
    bus.op_addr   = 12'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;

    // 1. reset and idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_ac", 32'(bus.ac), 32'h0);
    check("rst_e", 32'(bus.e), 32'd0);
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_aselect", 32'(bus.aselect), 32'b110);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // reset mid-FETCH drops mem_req immediately
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd2;
    bus.op_addr  = 12'h123;
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("mid_fetch_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_ready", 32'(bus.op_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 2. LDA with ack after 3 wait cycles
    mem_op(4'd2, 12'h05A, 16'h1234, 3);
    check("lda_ac", 32'(bus.ac), 32'h1234);
    check("lda_e", 32'(bus.e), 32'd0);

    // 3. ADD wrap, then skips
    mem_op(4'd2, 12'h001, 16'hFFFF, 0);
    reg_op(4'd4, 3'b110, 1'b0, 1'b0);
    mem_op(4'd1, 12'h002, 16'h0001, 1);
    check("add_ac", 32'(bus.ac), 32'h0000);
    check("add_e", 32'(bus.e), 32'd1);
    check("add_z", 32'(bus.z_flag), 32'd1);
    reg_op(4'd12, 3'b110, 1'b1, 1'b0);
    reg_op(4'd11, 3'b110, 1'b0, 1'b0);
    reg_op(4'd13, 3'b110, 1'b0, 1'b0);

    // 4. circulates
    mem_op(4'd2, 12'h003, 16'h8001, 0);
    reg_op(4'd4, 3'b110, 1'b0, 1'b0);
    reg_op(4'd8, 3'b101, 1'b0, 1'b0);
    check("cil_ac", 32'(bus.ac), 32'h0002);
    check("cil_e", 32'(bus.e), 32'd1);
    mem_op(4'd2, 12'h004, 16'h0003, 2);
    reg_op(4'd7, 3'b100, 1'b0, 1'b0);
    check("cir_ac", 32'(bus.ac), 32'h8001);
    check("cir_e", 32'(bus.e), 32'd1);
    check("cir_n", 32'(bus.n_flag), 32'd1);
    reg_op(4'd10, 3'b110, 1'b0, 1'b0);

    // 5. INC, CMA, CME twice
    mem_op(4'd2, 12'h005, 16'hFFFF, 0);
    reg_op(4'd4, 3'b110, 1'b0, 1'b0);
    reg_op(4'd9, 3'b001, 1'b0, 1'b0);
    check("inc_ac", 32'(bus.ac), 32'h0000);
    check("inc_e", 32'(bus.e), 32'd0);
    mem_op(4'd2, 12'h006, 16'h00FF, 0);
    reg_op(4'd5, 3'b011, 1'b0, 1'b0);
    check("cma_ac", 32'(bus.ac), 32'hFF00);
    reg_op(4'd6, 3'b110, 1'b0, 1'b0);
    check("cme1_e", 32'(bus.e), 32'd1);
    reg_op(4'd13, 3'b110, 1'b0, 1'b0);
    reg_op(4'd6, 3'b110, 1'b0, 1'b0);
    check("cme2_e", 32'(bus.e), 32'd0);

    // 6. AND timeout: 15 wait cycles, then err with AC untouched
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd0;
    bus.op_addr  = 12'h0AA;
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_req", 32'(bus.mem_req), 32'd1);
      check("to_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    check("to_req_drop", 32'(bus.mem_req), 32'd0);
    check("to_done", 32'(bus.done), 32'd1);
    check("to_err", 32'(bus.err), 32'd1);
    check("to_ac", 32'(bus.ac), 32'hFF00);
    tick();
    check("to_ready", 32'(bus.op_ready), 32'd1);
    // late ack outside FETCH must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5555;
    tick();
    bus.mem_ack   = 1'b0;
    check("stray_ack_ac", 32'(bus.ac), 32'hFF00);

    // ack in the last allowed cycle wins over timeout
    mem_op(4'd0, 12'h0BB, 16'h0F0F, 14);
    check("and_ac", 32'(bus.ac), 32'h0F00);

    // illegal op
    reg_op(4'd14, 3'b110, 1'b0, 1'b1);
    check("illegal_ac", 32'(bus.ac), 32'h0F00);
    reg_op(4'd3, 3'b110, 1'b0, 1'b0);
    check("cla_ac", 32'(bus.ac), 32'h0000);
    check("cla_z", 32'(bus.z_flag), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
